// File: rtl/ad9228_multi_ch_capture.sv
// Triggered multi-channel record buffer: circular pre-trigger history, frozen record, channel-interleaved readout.
// Optional level-crossing trigger is built when ADC_CAPTURE_THRESH_TRIG_EN is defined.
module ad9228_multi_ch_capture #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 2048,
    parameter int PTR_W      = $clog2(DEPTH),
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic                         s_valid,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         sw_trig,
    input  logic                         ext_trig,
    input  logic [CH_W-1:0]              trig_ch,
    input  logic [DATA_WIDTH-1:0]        trig_threshold,
    input  logic [PTR_W-1:0]             pre_samples,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]              m_ch,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_FILL = 3'd1,
        ARMED    = 3'd2,
        POST     = 3'd3,
        READOUT  = 3'd4
    } state_t;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_MAX = {PTR_W{1'b1}};
    localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1'b1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 32'd1);

    logic [NUM_CH*DATA_WIDTH-1:0] ram_q [DEPTH];
    logic [NUM_CH*DATA_WIDTH-1:0] rd_frame_q;
    state_t                       state_q;
    logic [PTR_W-1:0]             wr_ptr_q, cnt_q, pre_q, iss_frame_q;
    logic [CH_W-1:0]              iss_ch_q, ch1_q, m_ch_q;
    logic                         iss_done_q, v1_q, last1_q, pend_q, ext_prev_q;
    logic [DATA_WIDTH-1:0]        m_data_q;
    logic                         m_valid_q, m_last_q, busy_q, done_q, overrun_q;

    logic                         we_s, adv_s, iss_valid_s, iss_last_s, ext_rise_s, lvl_cross_s, trig_s;
    logic [PTR_W-1:0]             rd_addr_s, post_last_s;

    assign we_s        = s_valid && !rst && !abort
                         && (state_q == PRE_FILL || state_q == ARMED || state_q == POST);
    assign adv_s       = !m_valid_q || m_ready;
    assign iss_valid_s = (state_q == READOUT) && !iss_done_q;
    assign iss_last_s  = (iss_frame_q == PTR_MAX) && (iss_ch_q == CH_LAST);
    assign rd_addr_s   = wr_ptr_q + iss_frame_q;
    assign post_last_s = PTR_MAX - pre_q;
    assign ext_rise_s  = ext_trig && !ext_prev_q;
    assign trig_s      = pend_q || sw_trig || ext_rise_s || lvl_cross_s;

    // External trigger history for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) ext_prev_q <= 1'b0;
        else     ext_prev_q <= ext_trig;
    end

`ifdef ADC_CAPTURE_THRESH_TRIG_EN
    logic [DATA_WIDTH-1:0] prev_lvl_q;
    logic [DATA_WIDTH-1:0] cur_lvl_s;

    assign cur_lvl_s   = s_data[trig_ch*DATA_WIDTH +: DATA_WIDTH];
    assign lvl_cross_s = s_valid && (prev_lvl_q < trig_threshold) && (trig_threshold <= cur_lvl_s);

    // Previous trigger-channel sample, tracked on every valid frame
    always_ff @(posedge clk) begin
        if (rst)          prev_lvl_q <= '0;
        else if (s_valid) prev_lvl_q <= cur_lvl_s;
    end
`else
    logic unused_s;
    assign unused_s    = ^{trig_ch, trig_threshold};
    assign lvl_cross_s = 1'b0;
`endif

    // Sample RAM: capture write port, read port advancing with the output pipeline
    always_ff @(posedge clk) begin
        if (we_s)  ram_q[wr_ptr_q] <= s_data;
        if (adv_s) rd_frame_q      <= ram_q[rd_addr_s];
    end

    // Capture FSM, readout token issue, prefetch stage and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            pend_q      <= 1'b0;
            iss_frame_q <= '0;
            iss_ch_q    <= '0;
            iss_done_q  <= 1'b0;
            v1_q        <= 1'b0;
            ch1_q       <= '0;
            last1_q     <= 1'b0;
            m_data_q    <= '0;
            m_ch_q      <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (we_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (s_valid && state_q == READOUT) overrun_q <= 1'b1;
            if (abort) begin
                state_q   <= IDLE;
                pend_q    <= 1'b0;
                v1_q      <= 1'b0;
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (arm) begin
                            pre_q       <= pre_samples;
                            cnt_q       <= '0;
                            iss_frame_q <= '0;
                            iss_ch_q    <= '0;
                            iss_done_q  <= 1'b0;
                            overrun_q   <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= (pre_samples == '0) ? ARMED : PRE_FILL;
                        end
                    end
                    PRE_FILL: begin
                        if (s_valid) begin
                            if (cnt_q + PTR_ONE == pre_q) state_q <= ARMED;
                            else                          cnt_q   <= cnt_q + PTR_ONE;
                        end
                    end
                    ARMED: begin
                        // The trigger frame is post frame 0; a full pre window needs no further post frames
                        if (s_valid && trig_s) begin
                            pend_q  <= 1'b0;
                            cnt_q   <= PTR_ONE;
                            state_q <= (post_last_s == '0) ? READOUT : POST;
                        end else if (sw_trig || ext_rise_s) begin
                            pend_q <= 1'b1;
                        end
                    end
                    POST: begin
                        if (s_valid) begin
                            if (cnt_q == post_last_s) state_q <= READOUT;
                            else                      cnt_q   <= cnt_q + PTR_ONE;
                        end
                    end
                    READOUT: begin
                        if (adv_s) begin
                            m_valid_q <= v1_q;
                            m_data_q  <= rd_frame_q[ch1_q*DATA_WIDTH +: DATA_WIDTH];
                            m_ch_q    <= ch1_q;
                            m_last_q  <= last1_q;
                            v1_q      <= iss_valid_s;
                            ch1_q     <= iss_ch_q;
                            last1_q   <= iss_last_s;
                            if (iss_valid_s) begin
                                if (iss_ch_q == CH_LAST) begin
                                    iss_ch_q    <= '0;
                                    iss_frame_q <= iss_frame_q + PTR_ONE;
                                    iss_done_q  <= (iss_frame_q == PTR_MAX);
                                end else begin
                                    iss_ch_q <= iss_ch_q + CH_ONE;
                                end
                            end
                        end
                        if (m_valid_q && m_ready && m_last_q) begin
                            state_q   <= IDLE;
                            m_valid_q <= 1'b0;
                            v1_q      <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign m_data  = m_data_q;
    assign m_ch    = m_ch_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;
endmodule
